// File: rtl/vram_port_arbiter_pkg.sv
// Shared constants, index-width helper and read-tag type for the VRAM port-A arbiter.
package vram_arb_pkg;

  localparam int unsigned DEF_NUM_REQ    = 4;
  localparam int unsigned DEF_ADDR_W     = 16;
  localparam int unsigned DEF_DATA_W     = 32;
  localparam int unsigned DEF_RD_LATENCY = 2;

  // Tag index is sized for the largest supported requester count (8).
  localparam int unsigned TAG_IDX_W = 3;

  // Encoded requester index width; never narrower than one bit.
  function automatic int unsigned idx_width(input int unsigned n);
    int unsigned w;
    w = (n <= 32'd2) ? 32'd1 : 32'($clog2(n));
    return w;
  endfunction

  // One stage of the read-return tag pipeline.
  typedef struct packed {
    logic                 valid;
    logic [TAG_IDX_W-1:0] idx;
  } tag_t;

endpackage

// File: rtl/vram_port_arbiter_if.sv
// Requester-side bus of the VRAM arbiter: requests, grants and tagged read return.
interface vram_port_arbiter_if
  import vram_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = DEF_NUM_REQ,
  parameter int unsigned ADDR_W  = DEF_ADDR_W,
  parameter int unsigned DATA_W  = DEF_DATA_W
);

  logic [NUM_REQ-1:0]        req;
  logic [NUM_REQ-1:0]        req_wren;
  logic [NUM_REQ*ADDR_W-1:0] req_addr;
  logic [NUM_REQ*DATA_W-1:0] req_wdata;
  logic [NUM_REQ-1:0]        gnt;
  logic [NUM_REQ-1:0]        rvalid;
  logic [DATA_W-1:0]         rdata;

  // Requesters drive commands and observe grants/returns.
  modport master (
    output req, req_wren, req_addr, req_wdata,
    input  gnt, rvalid, rdata
  );

  // Arbiter consumes commands and produces grants/returns.
  modport slave (
    input  req, req_wren, req_addr, req_wdata,
    output gnt, rvalid, rdata
  );

endinterface

// File: rtl/vram_port_arbiter_rr_select.sv
// Requester selection: one-hot grant plus encoded index for the VRAM arbiter.
// Build option VRAM_ARB_FIXED_PRIO_EN: lowest index wins and last_ptr is ignored;
// otherwise round-robin starting just after last_ptr.
module rr_select #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned IDX_W   = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   last_ptr,
  input  logic               enable,
  output logic [NUM_REQ-1:0] gnt_c,
  output logic [IDX_W-1:0]   idx_c
);

  logic              found;
  logic [IDX_W-1:0]  cidx;
  int unsigned       cand;

`ifdef VRAM_ARB_FIXED_PRIO_EN
  logic unused_last_ptr;
  assign unused_last_ptr = ^last_ptr;

  // Fixed priority: first asserted request scanning upward from index 0.
  always_comb begin
    gnt_c = '0;
    idx_c = '0;
    found = 1'b0;
    cand  = '0;
    cidx  = '0;
    if (enable) begin
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
        cand = k;
        cidx = IDX_W'(cand);
        if (!found && req[cidx]) begin
          found       = 1'b1;
          gnt_c[cidx] = 1'b1;
          idx_c       = cidx;
        end
      end
    end
  end
`else
  // Round-robin: scan last_ptr+1 .. last_ptr+NUM_REQ modulo NUM_REQ.
  always_comb begin
    gnt_c = '0;
    idx_c = '0;
    found = 1'b0;
    cand  = '0;
    cidx  = '0;
    if (enable) begin
      for (int unsigned k = 1; k <= NUM_REQ; k++) begin
        cand = (32'(last_ptr) + k) % NUM_REQ;
        cidx = IDX_W'(cand);
        if (!found && req[cidx]) begin
          found       = 1'b1;
          gnt_c[cidx] = 1'b1;
          idx_c       = cidx;
        end
      end
    end
  end
`endif

endmodule

// File: rtl/vram_port_arbiter.sv
// VRAM port-A arbiter: grant selection, registered RAM command, read-tag pipeline, idle.
// Build option VRAM_ARB_FIXED_PRIO_EN selects fixed priority instead of round-robin.
module vram_port_arbiter
  import vram_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ    = DEF_NUM_REQ,
  parameter int unsigned ADDR_W     = DEF_ADDR_W,
  parameter int unsigned DATA_W     = DEF_DATA_W,
  parameter int unsigned RD_LATENCY = DEF_RD_LATENCY
) (
  input  logic               clk,
  input  logic               reset_sink_reset,
  input  logic               enable,
  vram_port_arbiter_if.slave bus,
  output logic [ADDR_W-1:0]  ram_address,
  output logic [DATA_W-1:0]  ram_data,
  output logic               ram_wren,
  input  logic [DATA_W-1:0]  ram_q,
  output logic               idle
);

  localparam int unsigned IDX_W = idx_width(NUM_REQ);
  localparam int unsigned NSTG  = RD_LATENCY + 1;

  logic [NUM_REQ-1:0] gnt_c;
  logic [IDX_W-1:0]   sel_idx_c;
  logic               any_gnt_c;
  logic               sel_enable_c;

  logic [IDX_W-1:0]   last_ptr_q, last_ptr_d;
  logic [ADDR_W-1:0]  ram_address_q, ram_address_d;
  logic [DATA_W-1:0]  ram_data_q, ram_data_d;
  logic               ram_wren_q, ram_wren_d;

  tag_t [NSTG-1:0]    tag_q, tag_d;
  tag_t               tag_head_c;
  logic [NSTG-1:0]    tag_valid_c;
  logic [NUM_REQ-1:0] rvalid_c;

  logic [ADDR_W-1:0]  addr_arr_c [NUM_REQ];
  logic [DATA_W-1:0]  data_arr_c [NUM_REQ];

  logic               unused_tag_idx;
  assign unused_tag_idx = ^tag_q[NSTG-1].idx;

  // Unpack the flattened per-requester address/data buses.
  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign addr_arr_c[g] = bus.req_addr[g*ADDR_W +: ADDR_W];
    assign data_arr_c[g] = bus.req_wdata[g*DATA_W +: DATA_W];
  end

  // No grants while held in reset.
  assign sel_enable_c = enable & ~reset_sink_reset;

  rr_select #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr_select (
    .req      (bus.req),
    .last_ptr (last_ptr_q),
    .enable   (sel_enable_c),
    .gnt_c    (gnt_c),
    .idx_c    (sel_idx_c)
  );

  assign any_gnt_c = |gnt_c;

  // Next pointer and RAM command from this cycle's grant.
  always_comb begin
    last_ptr_d    = last_ptr_q;
    ram_address_d = ram_address_q;
    ram_data_d    = ram_data_q;
    ram_wren_d    = 1'b0;
    if (any_gnt_c) begin
`ifndef VRAM_ARB_FIXED_PRIO_EN
      last_ptr_d    = sel_idx_c;
`endif
      ram_address_d = addr_arr_c[sel_idx_c];
      ram_data_d    = data_arr_c[sel_idx_c];
      ram_wren_d    = bus.req_wren[sel_idx_c];
    end
  end

  // Tag pipeline: granted reads enter at stage 0, writes and idle cycles insert bubbles.
  always_comb begin
    tag_head_c       = '0;
    tag_head_c.valid = any_gnt_c & ~bus.req_wren[sel_idx_c];
    tag_head_c.idx   = TAG_IDX_W'(sel_idx_c);
    tag_d            = {tag_q[NSTG-2:0], tag_head_c};
  end

  // Pointer, command and tag state.
  always_ff @(posedge clk) begin
    if (reset_sink_reset) begin
      last_ptr_q    <= IDX_W'(NUM_REQ - 1);
      ram_address_q <= '0;
      ram_data_q    <= '0;
      ram_wren_q    <= 1'b0;
      tag_q         <= '0;
    end else begin
      last_ptr_q    <= last_ptr_d;
      ram_address_q <= ram_address_d;
      ram_data_q    <= ram_data_d;
      ram_wren_q    <= ram_wren_d;
      tag_q         <= tag_d;
    end
  end

  for (genvar g = 0; g < NSTG; g++) begin : g_valid
    assign tag_valid_c[g] = tag_q[g].valid;
  end

  // Final tag stage lines up with ram_q; decode it to the owner's rvalid.
  always_comb begin
    rvalid_c = '0;
    if (tag_q[NSTG-1].valid && !reset_sink_reset) begin
      rvalid_c[tag_q[NSTG-1].idx[IDX_W-1:0]] = 1'b1;
    end
  end

  assign bus.gnt     = gnt_c;
  assign bus.rvalid  = rvalid_c;
  assign bus.rdata   = ram_q;
  assign ram_address = ram_address_q;
  assign ram_data    = ram_data_q;
  assign ram_wren    = ram_wren_q;
  assign idle        = ~any_gnt_c & ~(|tag_valid_c);

endmodule

// File: tb/tb_vram_port_arbiter.sv
// Scoreboard bench for vram_port_arbiter with a behavioural port-A RAM model.
module tb_vram_port_arbiter;

  localparam int unsigned NR = 4;
  localparam int unsigned AW = 16;
  localparam int unsigned DW = 32;
  localparam int unsigned L  = 2;

  typedef struct {
    int          due;
    int          idx;
    logic [31:0] data;
  } sb_t;

  logic          clk;
  logic          rst;
  logic          enable;
  logic [AW-1:0] ram_address;
  logic [DW-1:0] ram_data;
  logic          ram_wren;
  logic [DW-1:0] ram_q;
  logic          idle;

  int checks;
  int errors;
  int cyc;
  logic mon_en;
  sb_t sb[$];
  logic [NR-1:0] mon_exp;

  logic [31:0] ram_mem [65536];
  logic [31:0] exp_mem [65536];
  logic [31:0] q_pipe [L];
  logic        pre_en;
  logic [15:0] pre_addr;
  logic [31:0] pre_data;

  vram_port_arbiter_if #(.NUM_REQ(NR), .ADDR_W(AW), .DATA_W(DW)) bus ();

  vram_port_arbiter #(
    .NUM_REQ(NR), .ADDR_W(AW), .DATA_W(DW), .RD_LATENCY(L)
  ) dut (
    .clk              (clk),
    .reset_sink_reset (rst),
    .enable           (enable),
    .bus              (bus),
    .ram_address      (ram_address),
    .ram_data         (ram_data),
    .ram_wren         (ram_wren),
    .ram_q            (ram_q),
    .idle             (idle)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // RAM model: address sampled at the edge, q appears L cycles later.
  always @(posedge clk) begin
    if (pre_en) ram_mem[pre_addr] <= pre_data;
    else if (ram_wren) ram_mem[ram_address] <= ram_data;
    q_pipe[0] <= ram_mem[ram_address];
    for (int k = 1; k < L; k++) q_pipe[k] <= q_pipe[k-1];
  end
  assign ram_q = q_pipe[L-1];

  // Read-return monitor against the scoreboard.
  always @(negedge clk) begin
    if (mon_en) begin
      mon_exp = '0;
      if (sb.size() != 0 && sb[0].due < cyc) begin
        checks++; errors++;
        $display("FAIL rvalid_missed: idx %0d due cycle %0d not returned by cycle %0d", sb[0].idx, sb[0].due, cyc);
        void'(sb.pop_front());
      end
      if (sb.size() != 0 && sb[0].due == cyc) mon_exp[sb[0].idx] = 1'b1;
      checks++;
      if (bus.rvalid !== mon_exp) begin
        errors++;
        $display("FAIL rvalid: cycle %0d got %b expected %b", cyc, bus.rvalid, mon_exp);
      end
      if (mon_exp != '0) begin
        checks++;
        if (bus.rdata !== sb[0].data) begin
          errors++;
          $display("FAIL rdata: idx %0d got %h expected %h", sb[0].idx, bus.rdata, sb[0].data);
        end
        void'(sb.pop_front());
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation still running at 500000 ns, expected to finish");
    $fatal(1);
  end

  task automatic push_read(input int idx, input logic [15:0] addr);
    sb.push_back('{due: cyc + 1 + int'(L), idx: idx, data: exp_mem[addr]});
  endtask

  task automatic preload(input logic [15:0] addr, input logic [31:0] data);
    pre_addr = addr; pre_data = data; pre_en = 1'b1;
    exp_mem[addr] = data;
    @(posedge clk); #1;
    pre_en = 1'b0;
  endtask

  task automatic set_req(input int i, input logic wren, input logic [15:0] addr, input logic [31:0] wdata);
    bus.req[i] = 1'b1;
    bus.req_wren[i] = wren;
    bus.req_addr[i*AW +: AW] = addr;
    bus.req_wdata[i*DW +: DW] = wdata;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1; bus.req = '0; sb.delete();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic wait_idle();
    bit seen;
    seen = 1'b0;
    for (int k = 0; k < 20 && !seen; k++) begin
      @(negedge clk);
      if (idle === 1'b1 && sb.size() == 0) seen = 1'b1;
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL drain: idle=%b after 20 cycles, expected 1", idle);
    end
  endtask

  task automatic test_reset();
    @(posedge clk); #1;
    bus.req = 4'b0001;
    @(negedge clk);
    checks++; if (bus.gnt !== 4'b0000) begin errors++; $display("FAIL reset_gnt: got %b expected 0000", bus.gnt); end
    checks++; if (bus.rvalid !== 4'b0000) begin errors++; $display("FAIL reset_rvalid: got %b expected 0000", bus.rvalid); end
    checks++; if (idle !== 1'b1) begin errors++; $display("FAIL reset_idle: got %b expected 1", idle); end
    checks++; if (ram_wren !== 1'b0) begin errors++; $display("FAIL reset_wren: got %b expected 0", ram_wren); end
    checks++; if (ram_address !== 16'h0000) begin errors++; $display("FAIL reset_addr: got %h expected 0000", ram_address); end
    checks++; if (ram_data !== 32'h0) begin errors++; $display("FAIL reset_data: got %h expected 0", ram_data); end
    @(posedge clk); #1;
    bus.req = '0; rst = 1'b0; mon_en = 1'b1;
  endtask

  task automatic test_single_read();
    @(posedge clk); #1;
    set_req(0, 1'b0, 16'h0010, 32'h0);
    @(negedge clk);
    checks++; if (bus.gnt !== 4'b0001) begin errors++; $display("FAIL single_gnt: got %b expected 0001", bus.gnt); end
    checks++; if (idle !== 1'b0) begin errors++; $display("FAIL single_idle_T: got %b expected 0", idle); end
    push_read(0, 16'h0010);
    @(posedge clk); #1;
    bus.req = '0;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      if (k == 1) begin
        checks++; if (ram_address !== 16'h0010) begin errors++; $display("FAIL single_addr: got %h expected 0010", ram_address); end
        checks++; if (ram_wren !== 1'b0) begin errors++; $display("FAIL single_wren: got %b expected 0", ram_wren); end
      end
      checks++;
      if (idle !== (k >= 4)) begin errors++; $display("FAIL single_idle_T%0d: got %b expected %b", k, idle, (k >= 4)); end
    end
  endtask

  task automatic test_full_contention();
    int e;
    do_reset();
    for (int i = 0; i < 4; i++) set_req(i, 1'b0, 16'(16'h0020 + i), 32'h0);
    for (int n = 0; n < 8; n++) begin
      @(negedge clk);
      e = n % 4;
      checks++; if (bus.gnt !== 4'(1 << e)) begin errors++; $display("FAIL contention_gnt%0d: got %b expected %b", n, bus.gnt, 4'(1 << e)); end
      checks++; if (idle !== 1'b0) begin errors++; $display("FAIL contention_idle%0d: got %b expected 0", n, idle); end
      push_read(e, 16'(16'h0020 + e));
      @(posedge clk); #1;
    end
    bus.req = '0;
    wait_idle();
  endtask

  task automatic test_write_read();
    @(posedge clk); #1;
    set_req(2, 1'b1, 16'h0100, 32'h12345678);
    @(negedge clk);
    checks++; if (bus.gnt !== 4'b0100) begin errors++; $display("FAIL wr_gnt: got %b expected 0100", bus.gnt); end
    exp_mem[16'h0100] = 32'h12345678;
    @(posedge clk); #1;
    bus.req_wren[2] = 1'b0;
    @(negedge clk);
    checks++; if (ram_wren !== 1'b1) begin errors++; $display("FAIL wr_wren: got %b expected 1", ram_wren); end
    checks++; if (ram_address !== 16'h0100) begin errors++; $display("FAIL wr_addr: got %h expected 0100", ram_address); end
    checks++; if (ram_data !== 32'h12345678) begin errors++; $display("FAIL wr_data: got %h expected 12345678", ram_data); end
    checks++; if (bus.gnt !== 4'b0100) begin errors++; $display("FAIL rd_gnt: got %b expected 0100", bus.gnt); end
    push_read(2, 16'h0100);
    @(posedge clk); #1;
    bus.req = '0;
    @(negedge clk);
    checks++; if (ram_wren !== 1'b0) begin errors++; $display("FAIL wr_wren_once: got %b expected 0", ram_wren); end
    wait_idle();
  endtask

  task automatic test_enable_gating();
    @(posedge clk); #1;
    enable = 1'b0;
    set_req(1, 1'b0, 16'h0030, 32'h0);
    repeat (5) begin
      @(negedge clk);
      checks++; if (bus.gnt !== 4'b0000) begin errors++; $display("FAIL gate_gnt: got %b expected 0000", bus.gnt); end
      checks++; if (idle !== 1'b1) begin errors++; $display("FAIL gate_idle: got %b expected 1", idle); end
    end
    @(posedge clk); #1;
    enable = 1'b1;
    @(negedge clk);
    checks++; if (bus.gnt !== 4'b0010) begin errors++; $display("FAIL gate_release_gnt: got %b expected 0010", bus.gnt); end
    push_read(1, 16'h0030);
    @(posedge clk); #1;
    bus.req = '0;
    wait_idle();
  endtask

  task automatic test_reset_midflight();
    @(posedge clk); #1;
    set_req(0, 1'b0, 16'h0050, 32'h0);
    @(negedge clk);
    checks++; if (bus.gnt !== 4'b0001) begin errors++; $display("FAIL mid_gnt: got %b expected 0001", bus.gnt); end
    @(posedge clk); #1;
    rst = 1'b1; bus.req = '0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    checks++; if (idle !== 1'b1) begin errors++; $display("FAIL mid_idle: got %b expected 1", idle); end
    checks++; if (ram_wren !== 1'b0) begin errors++; $display("FAIL mid_wren: got %b expected 0", ram_wren); end
    @(posedge clk); #1;
    set_req(0, 1'b0, 16'h0050, 32'h0);
    set_req(3, 1'b0, 16'h0053, 32'h0);
    @(negedge clk);
    checks++; if (bus.gnt !== 4'b0001) begin errors++; $display("FAIL mid_rearb0: got %b expected 0001", bus.gnt); end
    push_read(0, 16'h0050);
    @(posedge clk); #1;
    bus.req[0] = 1'b0;
    @(negedge clk);
    checks++; if (bus.gnt !== 4'b1000) begin errors++; $display("FAIL mid_rearb3: got %b expected 1000", bus.gnt); end
    push_read(3, 16'h0053);
    @(posedge clk); #1;
    bus.req = '0;
    wait_idle();
  endtask

  task automatic test_sparse_priority();
    int e;
    do_reset();
    set_req(1, 1'b0, 16'h0041, 32'h0);
    set_req(3, 1'b0, 16'h0043, 32'h0);
    for (int n = 0; n < 6; n++) begin
      @(negedge clk);
`ifdef VRAM_ARB_FIXED_PRIO_EN
      e = 1;
`else
      e = (n % 2 == 0) ? 1 : 3;
`endif
      checks++; if (bus.gnt !== 4'(1 << e)) begin errors++; $display("FAIL sparse_gnt%0d: got %b expected %b", n, bus.gnt, 4'(1 << e)); end
      push_read(e, 16'(16'h0040 + e));
      @(posedge clk); #1;
    end
    bus.req = '0;
    wait_idle();
  endtask

  initial begin
    checks = 0; errors = 0; cyc = 0; mon_en = 1'b0;
    rst = 1'b1; enable = 1'b1; pre_en = 1'b0; pre_addr = '0; pre_data = '0;
    bus.req = '0; bus.req_wren = '0; bus.req_addr = '0; bus.req_wdata = '0;
    preload(16'h0010, 32'hDEADBEEF);
    for (int i = 0; i < 4; i++) preload(16'(16'h0020 + i), 32'hA0000000 + 32'(i) * 32'h1111);
    preload(16'h0030, 32'hCAFEF00D);
    for (int i = 0; i < 4; i++) preload(16'(16'h0040 + i), 32'h40400000 + 32'(i));
    preload(16'h0050, 32'h55550050);
    preload(16'h0053, 32'h55550053);
    test_reset();
    test_single_read();
    test_full_contention();
    test_write_read();
    test_enable_gating();
    test_reset_midflight();
    test_sparse_priority();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/vram_port_arbiter.md
Name: vram_port_arbiter

Overview:
- Shares video RAM port A (single clock, 1 access/cycle) among NUM_REQ videocard requesters (shader cores, blitter, DMA).
- Round-robin grant; registered RAM command; read data returned to the owner with a tagged valid after fixed RAM latency.
- Gated by an enable input from the start/finish control logic; reports idle so the finish interrupt is raised only after all traffic drains.

Parameters:
- NUM_REQ, 4, number of requesters (2..8)
- ADDR_W, 16, RAM word-address width
- DATA_W, 32, RAM data width
- RD_LATENCY, 2, cycles from registered command to valid ram_q (1..4)

Ports:
- clk  in  1  core clock (RAM port A clock)
- reset_sink_reset  in  1  synchronous, active-high reset
- enable  in  1  1 = new grants allowed
- req  in  NUM_REQ  per-requester request, held until granted
- req_wren  in  NUM_REQ  1 = write, 0 = read
- req_addr  in  NUM_REQ*ADDR_W  flattened, requester i at [i*ADDR_W +: ADDR_W]
- req_wdata  in  NUM_REQ*DATA_W  flattened write data
- gnt  out  NUM_REQ  one-hot acceptance, combinational in request cycle
- rvalid  out  NUM_REQ  one-hot read-data valid
- rdata  out  DATA_W  shared read data (= ram_q)
- ram_address  out  ADDR_W  to RAM address_a
- ram_data  out  DATA_W  to RAM data_a
- ram_wren  out  1  to RAM wren_a
- ram_q  in  DATA_W  from RAM q_a
- idle  out  1  no grant this cycle and no read in flight

Behaviour:
- Reset: last_ptr = NUM_REQ-1 (requester 0 wins first); ram_address = 0; ram_data = 0; ram_wren = 0; tag pipeline cleared. Outputs: gnt = 0, rvalid = 0, idle = 1.
- Grant (cycle T): if enable and any req, search indices last_ptr+1 .. last_ptr+NUM_REQ (mod NUM_REQ); grant the first with req=1. gnt is one-hot or zero; it is never asserted to an index whose req=0.
- The granted index becomes last_ptr at the end of T.
- Enable low: gnt = 0 and last_ptr is unchanged. Requests stay pending. In-flight reads complete normally.
- Command register: at the end of T, ram_address/ram_data/ram_wren load the granted requester's fields, so the RAM sees the command in T+1. With no grant, ram_wren = 0 and address/data hold their values.
- Requester may change addr/wdata/wren, or drop req, in T+1 after seeing gnt. Dropping req before a grant is legal; no access occurs.
- Read return: a read granted in T drives rvalid[i] = 1 in cycle T+1+RD_LATENCY, with rdata valid in that cycle only. No backpressure on read data.
- Tag pipeline: RD_LATENCY+1 stages of {valid, index}. Writes insert valid = 0.
- Writes produce no response; gnt is completion. A read granted after a write to the same address returns the new data (RAM read-during-write is not exercised across grants).
- Throughput: one grant per cycle sustained. Under continuous full request, each requester gets exactly one grant per NUM_REQ cycles.
- idle = ~|gnt & ~|tag_valid (all stages). Combinational.
- Reset mid-operation: in-flight reads are dropped (no rvalid), ram_wren clears, pointer resets. A requester's held req is re-arbitrated after reset.
- Widths: index width = clog2(NUM_REQ) (minimum 1). Pointer increment wraps modulo NUM_REQ; NUM_REQ not a power of two is supported.

Optional Feature:
- Macro: VRAM_ARB_FIXED_PRIO_EN.
- Defined: fixed priority, lowest index wins. last_ptr is not updated; starvation of high indices is permitted.
- Undefined: round-robin as above.
- Tag pipeline, latency and idle are identical in both modes.

Decomposition:
- Package vram_arb_pkg:
  - constants DEF_NUM_REQ, DEF_ADDR_W, DEF_DATA_W, DEF_RD_LATENCY
  - index-width function
  - tag struct {valid, idx}
- One sub-module: rr_select (req vector + last_ptr + enable -> one-hot gnt and encoded index). It contains the macro-controlled priority logic.
- Top holds the command register, tag pipeline and idle logic.

Test Plan:
- Single read: req[0]=1, addr 0x0010, RAM preloaded 0xDEADBEEF -> gnt[0] in T; ram_address=0x0010 in T+1; rvalid[0]=1 and rdata=0xDEADBEEF in T+3 only; idle=1 from T+4.
- Full contention: req=4'b1111 held for 8 cycles after each grant -> grant order 0,1,2,3,0,1,2,3; each gnt one-hot; no idle cycles.
- Write then read: req[2] writes 0x12345678 to 0x0100, then reads 0x0100 -> ram_wren=1 exactly one cycle; rvalid[2] returns 0x12345678 at grant+3.
- Enable gating: req[1]=1 with enable=0 for 5 cycles -> gnt=0, idle=1. Raise enable -> gnt[1] in the same cycle.
- Reset mid-flight: read granted in T, reset_sink_reset=1 in T+1 -> no rvalid ever for that read; ram_wren=0, idle=1 after reset.
- VRAM_ARB_FIXED_PRIO_EN defined, req=4'b1010 held -> gnt[1] every cycle; gnt[3] never asserted.
